// File: rtl/fifo_ctrl_ext.sv
// Control unit for the extended FIFO: pointers, occupancy count, status
// flags, read-valid strobe and sticky overflow/underflow flags.
module fifo_ctrl_ext #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int AF_THRESH     = 14,
    parameter int AE_THRESH     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] w_addr,
    output logic [ADDRESS_WIDTH-1:0] r_addr,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     rd_valid,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [ADDRESS_WIDTH:0]   DEPTH   = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   AF_C    = (ADDRESS_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   AE_C    = (ADDRESS_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDRESS_WIDTH-1:0] w_ptr;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [ADDRESS_WIDTH:0]   cnt;
    logic                     push_ok;
    logic                     pop_ok;

    always_comb begin
        full         = (cnt == DEPTH);
        empty        = (cnt == '0);
        almost_full  = (cnt >= AF_C);
        almost_empty = (cnt <= AE_C);
        push_ok      = wr && !full;
        pop_ok       = rd && !empty;
        wr_en        = push_ok;
        w_addr       = w_ptr;
        r_addr       = r_ptr;
        count        = cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            cnt       <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                w_ptr <= w_ptr + PTR_ONE;
            if (pop_ok)
                r_ptr <= r_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            rd_valid <= pop_ok;
            // A new error event wins over a coincident clear.
            if (wr && full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (rd && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule
